// File: rtl/btn_debounce_arbiter.sv
// -----------------------------------------------------------------------------
// btn_debounce_arbiter
//
// Debounces N raw push-button inputs with a single shared counter. A
// round-robin scheduler picks one button whose synchronized level differs
// from its accepted level, times how long the new level holds, and accepts
// it after LIMIT consecutive cycles. Accepted rising edges produce a
// one-cycle press pulse and an event in a 4-deep first-word-fall-through
// FIFO.
//
// Build option:
//   BTN_RELEASE_EVT_EN  when defined, accepted 1->0 changes also push an
//                       event {0,idx}. When undefined, releases only update
//                       level and every event carries MSB = 1.
//
// Parameters:
//   N      number of buttons (2..16)
//   LIMIT  cycles a changed level must hold before acceptance (>= 2)
//   CW     counter width, 2**CW > LIMIT
//
// Ports:
//   clk           system clock
//   nRst          asynchronous active-low reset
//   noisy[N]      raw button levels, asynchronous to clk
//   level[N]      debounced levels
//   press[N]      one-cycle pulse per accepted 0->1 change
//   evt_valid     FIFO non-empty
//   evt_code      {rise, index} at the FIFO head (0 when empty)
//   evt_ready     head is popped when evt_valid && evt_ready
//   overflow      sticky: an event was dropped because the FIFO was full
//   overflow_clr  clears overflow (a simultaneous new drop wins)
// -----------------------------------------------------------------------------
module btn_debounce_arbiter #(
   parameter int N     = 4,
   parameter int LIMIT = 100000,
   parameter int CW    = 17
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic [N-1:0]         noisy,
   output logic [N-1:0]         level,
   output logic [N-1:0]         press,
   output logic                 evt_valid,
   output logic [$clog2(N):0]   evt_code,
   input  logic                 evt_ready,
   output logic                 overflow,
   input  logic                 overflow_clr
);

   localparam int IW     = $clog2(N);
   localparam int CODE_W = IW + 1;

   typedef enum logic [1:0] {SCAN, COUNT, COMMIT} state_t;

   state_t              state, state_nx;
   logic [N-1:0]        sync_a, sync;
   logic [N-1:0]        cand;
   logic [IW-1:0]       ptr, ptr_nx;
   logic [IW-1:0]       idx, idx_nx, idx_inc;
   logic [IW-1:0]       pick;
   logic                found;
   int                  j;
   logic [CW-1:0]       counter, counter_nx;
   logic [N-1:0]        level_nx, press_nx;
   logic                push;
   logic [CODE_W-1:0]   push_code;

   // FIFO
   logic [CODE_W-1:0]   mem [4];
   logic [1:0]          rd_ptr, wr_ptr;
   logic [2:0]          count;
   logic                pop, full, accept, drop;

   assign cand    = sync ^ level;
   assign idx_inc = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;

   // First candidate at or after ptr, wrapping from N-1 back to 0.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      j     = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && cand[IW'(j)]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      idx_nx     = idx;
      counter_nx = counter;
      level_nx   = level;
      press_nx   = '0;
      push       = 1'b0;
      push_code  = '0;
      case (state)
         SCAN: begin
            if (found) begin
               idx_nx     = pick;
               counter_nx = '0;
               state_nx   = COUNT;
            end
         end
         COUNT: begin
            if (cand[idx]) begin
               if (counter == CW'(LIMIT - 1)) state_nx = COMMIT;
               else                           counter_nx = counter + 1'b1;
            end else begin
               // Level reverted before the hold time: give the next button a turn.
               ptr_nx   = idx_inc;
               state_nx = SCAN;
            end
         end
         COMMIT: begin
            ptr_nx   = idx_inc;
            state_nx = SCAN;
            // A bounce landing exactly in this cycle leaves level untouched.
            if (cand[idx]) begin
               level_nx[idx] = sync[idx];
               if (sync[idx]) begin
                  press_nx[idx] = 1'b1;
                  push          = 1'b1;
                  push_code     = {1'b1, idx};
               end
`ifdef BTN_RELEASE_EVT_EN
               else begin
                  push      = 1'b1;
                  push_code = {1'b0, idx};
               end
`else
`endif
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         sync_a  <= '0;
         sync    <= '0;
         state   <= SCAN;
         ptr     <= '0;
         idx     <= '0;
         counter <= '0;
         level   <= '0;
         press   <= '0;
      end else begin
         sync_a  <= noisy;
         sync    <= sync_a;
         state   <= state_nx;
         ptr     <= ptr_nx;
         idx     <= idx_nx;
         counter <= counter_nx;
         level   <= level_nx;
         press   <= press_nx;
      end
   end

   // A pop frees a slot in the same cycle, so push-while-full succeeds with it.
   assign evt_valid = (count != 3'd0);
   assign pop       = evt_valid && evt_ready;
   assign full      = (count == 3'd4);
   assign accept    = push && (!full || pop);
   assign drop      = push && full && !pop;
   assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (pop)    rd_ptr <= rd_ptr + 1'b1;
         if (accept) wr_ptr <= wr_ptr + 1'b1;
         if (accept && !pop)      count <= count + 1'b1;
         else if (!accept && pop) count <= count - 1'b1;
         if (drop)              overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr] <= push_code;
   end

endmodule

// File: doc/btn_debounce_arbiter.md
# btn_debounce_arbiter

Shares one debounce counter among N raw push-button inputs by round-robin scheduling. Per-button debounced levels, one-cycle press pulses and a 4-deep event FIFO are produced for the downstream control logic. It sits between the FPGA pin pads and the user-input/command logic, and replaces N per-button counters with one.

## Interface
- N, default 4: number of buttons, 2..16.
- LIMIT, default 100000: cycles a changed level must hold before it is accepted, ≥2.
- CW, default 17: counter width; requires 2^CW > LIMIT.
- clk  in  1  system clock (12 MHz).
- nRst  in  1  asynchronous, active-low reset.
- noisy  in  N  raw button levels, asynchronous to clk.
- level  out  N  debounced stable levels.
- press  out  N  one-cycle pulse per accepted 0→1 transition.
- evt_valid  out  1  FIFO non-empty.
- evt_code  out  $clog2(N)+1  {rise, index} of the FIFO head.
- evt_ready  in  1  consumer pops the head when evt_valid && evt_ready.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

## Operation
- Each noisy bit passes through a 2-FF synchronizer (sync). Candidate i means sync[i] != level[i].
- The FSM has three states: SCAN, COUNT and COMMIT.
- SCAN: pick the first candidate, searching round-robin from ptr upward with wrap at N-1→0. Latch it as idx, clear the counter, go to COUNT. With no candidate, stay in SCAN.
- COUNT: each cycle, if sync[idx] != level[idx], counter++. On a reach of LIMIT-1, go to COMMIT. On a revert (sync[idx]==level[idx]), abort: ptr←idx+1 (mod N), go to SCAN.
- COMMIT: level[idx]←sync[idx], ptr←idx+1 (mod N), go to SCAN.
  - If the new level is 1, press[idx] pulses and event {1,idx} is pushed.
  - If the new level is 0, a release is handled per Configuration.
- Only one button is under test at a time. Changes on other buttons wait. This gives a fairness bound of N commits or aborts.
- FIFO: depth 4, first-word fall-through; evt_code equals the head.
  - A push when full drops the event and sets overflow.
  - A push and pop in the same cycle when full succeeds with no overflow.
  - A push and pop in the same cycle when empty leaves one entry.
- If overflow_clr and a new overflow occur in the same cycle, overflow stays set.

## Timing
- Reset (async assert) values:
  - state=SCAN, ptr=0, idx=0, counter=0, sync=0.
  - level=0, press=0, FIFO empty (evt_valid=0, evt_code=0), overflow=0.
- Deassertion is sampled on the first rising clk.
- Latency, when no other button is in progress:
  - sync sees the change 2 cycles after noisy.
  - SCAN takes 1 cycle; COUNT takes LIMIT cycles; COMMIT takes 1 cycle.
  - level, press and the FIFO entry all update on the edge that ends COMMIT.
  - press is high for exactly the cycle after COMMIT.
- evt_valid rises in the same cycle as press.
- A pop takes effect at the clock edge where valid && ready holds.
- A glitch shorter than LIMIT cycles never changes level.
- Reset asserted mid-COUNT aborts the count immediately. No partial event is produced.

## Configuration
- BTN_RELEASE_EVT_EN defined: an accepted 1→0 change pushes event {0,idx} into the FIFO. It is subject to the same overflow rules.
- BTN_RELEASE_EVT_EN not defined: a 1→0 change updates level only. No FIFO push occurs and the event MSB is always 1.
- press behaviour is identical in both builds.

## Test plan
All scenarios use N=4, LIMIT=4 unless stated.
- Reset: hold nRst=0 with noisy=4'hF → level=0, press=0, evt_valid=0, overflow=0; release reset → level=4'hF after 2+1+4+1 cycles per button in round-robin order 0,1,2,3.
- Single press: noisy[2] 0→1 and held → press[2] pulses exactly once; evt_code={1,2'd2}; level[2]=1; no other pulses.
- Glitch: noisy[1] high for 3 cycles, then low → abort, level[1]=0, no press, evt_valid=0; the next candidate is searched from ptr=2.
- Contention: noisy[0] and noisy[3] rise together → button 0 commits first, then 3; FIFO holds {1,0} then {1,3}; level updates are LIMIT+2 cycles apart.
- Overflow: evt_ready=0, 5 separate presses → 4 entries held, overflow=1; overflow_clr → 0; a pop while full plus a push in the same cycle → no overflow.
- Release, run in both builds: press then release button 1 → with BTN_RELEASE_EVT_EN the FIFO holds {1,1},{0,1}; without it the FIFO holds only {1,1}; level[1] returns to 0 in both.
